// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Purpose  : Types and constants shared by the APB master bridge and apb_ram.
//            - apb_master_state_t : bridge FSM state encoding
//            - APB_ADDR_WIDTH     : default APB address width (matches apb_ram)
//            - APB_DATA_WIDTH     : default APB data width
//            - RDATA_ERR          : read data returned on a timed-out transfer
// Revision : 1.0  initial release
// ============================================================================
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 5;
    localparam int APB_DATA_WIDTH = 32;
    localparam int RDATA_ERR      = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_master_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Purpose  : Turns a valid/ready command stream into APB3 transfers and
//            returns exactly one response per command. A pready timeout
//            aborts a transfer to a hung slave.
// Ports    : pclk, preset                 clock, synchronous active-high reset
//            cmd_valid/ready/write/addr/wdata   command channel (accepted in IDLE)
//            rsp_valid/ready/rdata/err/timeout  response channel
//            psel/penable/pwrite/paddr/pwdata   APB request outputs
//            prdata/pready/pslverr              APB completion inputs
// Revision : 1.0  initial release
// ============================================================================
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    // A disabled timeout still gets a 1-bit counter so no zero-width vector exists.
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST =
        c_CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = {c_CNT_W{1'b1}};
    localparam logic [DATA_WIDTH-1:0] c_RDATA_ERR = DATA_WIDTH'(RDATA_ERR);

    apb_master_state_t       r_state_q,       w_state_d;
    logic                    r_pwrite_q,      w_pwrite_d;
    logic [ADDR_WIDTH-1:0]   r_paddr_q,       w_paddr_d;
    logic [DATA_WIDTH-1:0]   r_pwdata_q,      w_pwdata_d;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata_q,   w_rsp_rdata_d;
    logic                    r_rsp_err_q,     w_rsp_err_d;
    logic                    r_rsp_timeout_q, w_rsp_timeout_d;
    logic [c_CNT_W-1:0]      r_wait_q,        w_wait_d;
    logic                    w_timeout_hit;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            // Last waited ACCESS edge allowed; pready on this edge still wins.
            assign w_timeout_hit = (r_wait_q == c_TO_LAST);
        end else begin : g_no_timeout
            assign w_timeout_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state_q       <= IDLE;
            r_pwrite_q      <= 1'b0;
            r_paddr_q       <= '0;
            r_pwdata_q      <= '0;
            r_rsp_rdata_q   <= '0;
            r_rsp_err_q     <= 1'b0;
            r_rsp_timeout_q <= 1'b0;
            r_wait_q        <= '0;
        end else begin
            r_state_q       <= w_state_d;
            r_pwrite_q      <= w_pwrite_d;
            r_paddr_q       <= w_paddr_d;
            r_pwdata_q      <= w_pwdata_d;
            r_rsp_rdata_q   <= w_rsp_rdata_d;
            r_rsp_err_q     <= w_rsp_err_d;
            r_rsp_timeout_q <= w_rsp_timeout_d;
            r_wait_q        <= w_wait_d;
        end
    end

    always_comb begin
        w_state_d       = r_state_q;
        w_pwrite_d      = r_pwrite_q;
        w_paddr_d       = r_paddr_q;
        w_pwdata_d      = r_pwdata_q;
        w_rsp_rdata_d   = r_rsp_rdata_q;
        w_rsp_err_d     = r_rsp_err_q;
        w_rsp_timeout_d = r_rsp_timeout_q;
        w_wait_d        = r_wait_q;

        unique case (r_state_q)
            IDLE: begin
                if (cmd_valid) begin
                    w_pwrite_d = cmd_write;
                    w_paddr_d  = cmd_addr;
                    w_pwdata_d = cmd_wdata;
                    w_wait_d   = '0;
                    w_state_d  = SETUP;
                end
            end
            SETUP: begin
                w_state_d = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    w_rsp_rdata_d   = r_pwrite_q ? '0 : prdata;
                    w_rsp_err_d     = pslverr;
                    w_rsp_timeout_d = 1'b0;
                    w_state_d       = RESP;
                end else if (w_timeout_hit) begin
                    w_rsp_rdata_d   = c_RDATA_ERR;
                    w_rsp_err_d     = 1'b1;
                    w_rsp_timeout_d = 1'b1;
                    w_state_d       = RESP;
                end else if (r_wait_q != c_CNT_MAX) begin
                    w_wait_d = r_wait_q + c_CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // Handshake and phase strobes are decoded straight from the state register,
    // so none of them has a combinational path from an input.
    assign cmd_ready   = (r_state_q == IDLE);
    assign psel        = (r_state_q == SETUP) || (r_state_q == ACCESS);
    assign penable     = (r_state_q == ACCESS);
    assign rsp_valid   = (r_state_q == RESP);
    assign pwrite      = r_pwrite_q;
    assign paddr       = r_paddr_q;
    assign pwdata      = r_pwdata_q;
    assign rsp_rdata   = r_rsp_rdata_q;
    assign rsp_err     = r_rsp_err_q;
    assign rsp_timeout = r_rsp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Purpose  : Self-checking bench for apb_master_bridge with a behavioural APB
//            slave (RAM with programmable wait states / error / hang) and a
//            reference model of command results.
// Revision : 1.0  initial release
// ============================================================================
module tb_apb_master_bridge;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          preset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err, rsp_timeout;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic          pready, pslverr;

    int checks = 0;
    int errors = 0;

    apb_master_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // ---------------- behavioural slave ----------------
    logic [DW-1:0] mem [32];
    logic          mem_clr = 1'b1;
    int            slv_wait = 0;       // ACCESS edges without pready before it is given
    logic          slv_err  = 1'b0;
    logic [DW-1:0] slv_data = '0;      // prdata returned on an error completion
    int            slv_cnt  = 0;

    assign pready  = psel && penable && (slv_cnt == slv_wait);
    assign pslverr = pready && slv_err;
    assign prdata  = slv_err ? slv_data : mem[paddr];

    always @(posedge pclk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (psel && penable && pready && pwrite && !slv_err) begin
            mem[paddr] <= pwdata;
        end
        if (psel && penable && !pready) slv_cnt <= slv_cnt + 1;
        else if (!penable)              slv_cnt <= 0;
    end

    // ---------------- monitors ----------------
    int            acc_edges = 0;
    int            stab_err  = 0;
    logic          mon_psel  = 1'b0;
    logic [AW-1:0] mon_addr;
    logic          mon_wr;
    logic [DW-1:0] mon_wd;

    always @(posedge pclk) begin
        if (psel && penable) acc_edges <= acc_edges + 1;
        if (psel && mon_psel && ({paddr, pwrite, pwdata} != {mon_addr, mon_wr, mon_wd}))
            stab_err <= stab_err + 1;
        if (penable && !psel) stab_err <= stab_err + 1;
        mon_psel <= psel;
        mon_addr <= paddr;
        mon_wr   <= pwrite;
        mon_wd   <= pwdata;
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [32];

    function automatic void ref_step(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                     input int wt, input logic se, input logic [DW-1:0] sd,
                                     output logic [DW-1:0] erd, output logic eerr,
                                     output logic eto, output int eacc);
        if (wt >= TO) begin
            // slave never answers within the timeout window
            eacc = TO; erd = '0; eerr = 1'b1; eto = 1'b1;
        end else begin
            eacc = wt + 1; eerr = se; eto = 1'b0;
            erd  = w ? '0 : (se ? sd : ref_mem[a]);
            if (w && !se) ref_mem[a] = d;
        end
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete command: accept, phase checks, response checks, handshake.
    task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int wt, input logic se, input logic [DW-1:0] sd, input int rdly,
                           input logic [DW-1:0] erd, input logic eerr, input logic eto,
                           input int eacc);
        int acc0;
        int cyc;
        slv_wait  = wt; slv_err = se; slv_data = sd;
        rsp_ready = (rdly == 0);
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        check("accept_ready", cmd_ready, 1'b1);
        cyc = 0;
        while (!cmd_ready && cyc < 40) begin @(posedge pclk); #1; cyc++; end
        if (!cmd_ready) begin cmd_valid = 1'b0; return; end
        acc0 = acc_edges;
        @(posedge pclk); #1;
        // keep offering a different command: it must be ignored while busy
        cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~d;
        check("setup_phase", {psel, penable, cmd_ready}, 3'b100);
        @(posedge pclk); #1;
        check("access_phase", {psel, penable}, 2'b11);
        cyc = 1;
        while (!rsp_valid && cyc < 60) begin @(posedge pclk); #1; cyc++; end
        check("rsp_latency", cyc, eacc + 1);
        check("access_edges", acc_edges - acc0, eacc);
        check("rsp_fields", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, psel, penable},
              {1'b1, erd, eerr, eto, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < rdly; i++) begin
            @(posedge pclk); #1;
            check("rsp_hold", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, psel},
                  {1'b1, erd, eerr, eto, 1'b0, 1'b0});
        end
        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        check("rsp_done", {rsp_valid, cmd_ready, psel}, 3'b010);
    endtask

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            wt;
        logic          se;
        logic [DW-1:0] sd;
        int            rdly;
        logic [DW-1:0] erd;
        logic          eerr;
        logic          eto;
        int            eacc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] erd;
        logic          eerr, eto, rv;
        int            eacc;
        logic          rw;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd, rsd;
        int            rwt, rsel;
        logic          rse;

        //              w     a      d             wt   se    sd            rdly erd           err   to    acc
        tbl[0] = '{1'b1, 5'd5, 32'hA5A5_0001,   1, 1'b0, 32'h0,           0, 32'h0,          1'b0, 1'b0, 2};
        tbl[1] = '{1'b0, 5'd5, 32'h0,           1, 1'b0, 32'h0,           0, 32'hA5A5_0001,  1'b0, 1'b0, 2};
        tbl[2] = '{1'b0, 5'd7, 32'h0,         100, 1'b0, 32'h0,           0, 32'h0,          1'b1, 1'b1, 16};
        tbl[3] = '{1'b0, 5'd3, 32'h0,           2, 1'b1, 32'hDEAD_BEEF,   0, 32'hDEAD_BEEF,  1'b1, 1'b0, 3};
        tbl[4] = '{1'b1, 5'd3, 32'h1111_2222,   0, 1'b0, 32'h0,           5, 32'h0,          1'b0, 1'b0, 1};
        tbl[5] = '{1'b0, 5'd3, 32'h0,           0, 1'b0, 32'h0,           0, 32'h1111_2222,  1'b0, 1'b0, 1};
        tbl[6] = '{1'b1, 5'd5, 32'hCAFE_F00D,  15, 1'b0, 32'h0,           0, 32'h0,          1'b0, 1'b0, 16};
        tbl[7] = '{1'b0, 5'd5, 32'h0,           0, 1'b0, 32'h0,           1, 32'hCAFE_F00D,  1'b0, 1'b0, 1};
        tbl[8] = '{1'b1, 5'd6, 32'h0000_0055,   0, 1'b1, 32'h7777_0000,   0, 32'h0,          1'b1, 1'b0, 1};
        tbl[9] = '{1'b0, 5'd6, 32'h0,           1, 1'b0, 32'h0,           0, 32'h0,          1'b0, 1'b0, 2};

        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("reset_state",
              {psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready},
              {1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1});
        preset = 1'b0; mem_clr = 1'b0;
        @(posedge pclk); #1;

        // directed table
        for (int i = 0; i < 10; i++) begin
            ref_step(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].wt, tbl[i].se, tbl[i].sd, erd, eerr, eto, eacc);
            run_cmd(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].wt, tbl[i].se, tbl[i].sd, tbl[i].rdly,
                    tbl[i].erd, tbl[i].eerr, tbl[i].eto, tbl[i].eacc);
            if (i == 0) check("mem5_written", mem[5], 32'hA5A5_0001);
        end

        // reset in the middle of a hung write: nothing may complete or respond
        slv_wait = 1000; slv_err = 1'b0; rsp_ready = 1'b1;
        cmd_write = 1'b1; cmd_addr = 5'd9; cmd_wdata = 32'h0000_1234; cmd_valid = 1'b1;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        check("mid_in_access", {psel, penable}, 2'b11);
        preset = 1'b1;
        @(posedge pclk); #1;
        check("mid_reset", {psel, penable, rsp_valid, cmd_ready}, 4'b0001);
        preset = 1'b0;
        rv = 1'b0;
        repeat (4) begin @(posedge pclk); #1; rv = rv | rsp_valid | psel; end
        check("mid_no_rsp", rv, 1'b0);

        // follow-up traffic completes normally; aborted write left no trace
        ref_step(1'b0, 5'd9, 32'h0, 1, 1'b0, 32'h0, erd, eerr, eto, eacc);
        run_cmd(1'b0, 5'd9, 32'h0, 1, 1'b0, 32'h0, 0, erd, eerr, eto, eacc);
        ref_step(1'b1, 5'd9, 32'hBEEF_0009, 1, 1'b0, 32'h0, erd, eerr, eto, eacc);
        run_cmd(1'b1, 5'd9, 32'hBEEF_0009, 1, 1'b0, 32'h0, 0, erd, eerr, eto, eacc);
        ref_step(1'b0, 5'd9, 32'h0, 0, 1'b0, 32'h0, erd, eerr, eto, eacc);
        run_cmd(1'b0, 5'd9, 32'h0, 0, 1'b0, 32'h0, 0, erd, eerr, eto, eacc);

        // randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            rw   = 1'($urandom_range(0, 1));
            ra   = AW'($urandom_range(0, 31));
            rd   = $urandom;
            rsd  = $urandom;
            rsel = $urandom_range(0, 9);
            rwt  = (rsel < 7) ? $urandom_range(0, 3) : $urandom_range(TO - 2, TO + 2);
            rse  = ($urandom_range(0, 7) == 0);
            ref_step(rw, ra, rd, rwt, rse, rsd, erd, eerr, eto, eacc);
            run_cmd(rw, ra, rd, rwt, rse, rsd, $urandom_range(0, 2), erd, eerr, eto, eacc);
        end

        check("apb_stable", stab_err, 0);
        for (int i = 0; i < 32; i++) check("mem_final", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
